// File: rtl/pio_in_irq_if.sv
// pio_in_irq_if: Avalon-MM slave bus of the input PIO (address, write strobe, read data, irq).
`default_nettype none

interface pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );
endinterface

`default_nettype wire

// File: rtl/pio_in_irq.sv
// pio_in_irq: WIDTH-bit input PIO with synchronizer, optional per-bit debouncer,
// sticky edge capture and maskable edge- or level-sourced interrupt.
`default_nettype none

module pio_in_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] in_port,
  pio_in_irq_if.slave           bus
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic [31:0]      r_rdata;
  logic             w_wr;
  logic             w_unused_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_nodb
    assign w_stable = w_sync;
  end else begin : g_db
    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_stable;

    // Any cycle where the input agrees with the accepted value restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_stable <= '0;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_sync[i] == r_stable[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == C_LAST) begin
            r_stable[i] <= w_sync[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end

    assign w_stable = r_stable;
  end

  assign w_rise = w_stable & ~r_prev;
  assign w_fall = ~w_stable & r_prev;

  always_comb begin
    w_edge = w_rise;
    if (EDGE_TYPE == 1)      w_edge = w_fall;
    else if (EDGE_TYPE == 2) w_edge = w_rise | w_fall;
  end

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_clr          = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^bus.writedata;

  // Edge set is OR'ed after the clear so a coincident edge survives the W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_mask <= '0;
      r_ecap <= '0;
    end else begin
      r_prev <= w_stable;
      r_ecap <= (r_ecap & ~w_clr) | w_edge;
      if (w_wr && bus.address == 2'd2) r_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      2'd0:    w_rdata[WIDTH-1:0] = w_stable;
      2'd2:    w_rdata[WIDTH-1:0] = r_mask;
      2'd3:    w_rdata[WIDTH-1:0] = r_ecap;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_rdata <= '0;
    else       r_rdata <= w_rdata;
  end

  assign bus.readdata = r_rdata;

  if (IRQ_TYPE == 1) begin : g_irq_level
    assign bus.irq = ~reset & (|(w_stable & r_mask));
  end else begin : g_irq_edge
    assign bus.irq = ~reset & (|(r_ecap & r_mask));
  end

endmodule

`default_nettype wire

// File: tb/tb_pio_in_irq.sv
// tb_pio_in_irq: three configurations (plain, debounced, level irq) checked through
// an expectation queue drained by an independent monitor one cycle after each request.
`default_nettype none

module tb_pio_in_irq;

  logic       clk;
  logic       reset;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_c;
  logic       rd_req;
  logic       rd_valid;
  int         checks;
  int         errors;

  pio_in_irq_if ifa ();
  pio_in_irq_if ifb ();
  pio_in_irq_if ifc ();

  pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0))
    u_a (.clk(clk), .reset(reset), .in_port(in_a), .bus(ifa));
  pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(0))
    u_b (.clk(clk), .reset(reset), .in_port(in_b), .bus(ifb));
  pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(1))
    u_c (.clk(clk), .reset(reset), .in_port(in_c), .bus(ifc));

  typedef struct {
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_valid <= rd_req;

  // Monitor: one expectation retires per cycle in which a request was presented.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: response with no expectation");
      end else begin
        m_e = q.pop_front();
        case (m_e.dut)
          0:       m_act = m_e.is_irq ? {31'b0, ifa.irq} : ifa.readdata;
          1:       m_act = m_e.is_irq ? {31'b0, ifb.irq} : ifb.readdata;
          default: m_act = m_e.is_irq ? {31'b0, ifc.irq} : ifc.readdata;
        endcase
        if (m_act !== m_e.exp) begin
          errors++;
          $display("FAIL %s dut%0d: actual %h required %h", m_e.name, m_e.dut, m_act, m_e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bus(input int d, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
    case (d)
      0: begin ifa.chipselect = cs; ifa.write_n = wn; ifa.address = a; ifa.writedata = wd; end
      1: begin ifb.chipselect = cs; ifb.write_n = wn; ifb.address = a; ifb.writedata = wd; end
      default: begin ifc.chipselect = cs; ifc.write_n = wn; ifc.address = a; ifc.writedata = wd; end
    endcase
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd);
    set_bus(d, 1'b1, 1'b0, a, wd);
    tick(1);
    set_bus(d, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  // Request: the value is observed after the next rising edge.
  task automatic chk(input int d, input bit is_irq, input logic [1:0] a,
                     input logic [31:0] exp, input string name);
    exp_t e;
    e.dut = d; e.is_irq = is_irq; e.exp = exp; e.name = name;
    set_bus(d, 1'b1, 1'b1, a, 32'h0);
    q.push_back(e);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    set_bus(d, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rd_req = 1'b0;
    reset  = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    for (int d = 0; d < 3; d++) set_bus(d, 1'b0, 1'b1, 2'd0, 32'h0);
    tick(4);
    chk(0, 1, 2'd0, 32'h0, "irq_in_reset_a");
    chk(2, 1, 2'd0, 32'h0, "irq_in_reset_c");
    reset = 1'b0;
    tick(1);

    for (int a = 0; a < 4; a++) chk(0, 0, 2'(a), 32'h0, "reset_read_a");
    chk(0, 1, 2'd0, 32'h0, "reset_irq_a");

    // Plain data path and W1C
    in_a = 8'hA5;
    tick(2);
    chk(0, 0, 2'd0, 32'h000000A5, "data_a5");
    chk(0, 0, 2'd3, 32'h000000A5, "ecap_a5");
    wr(0, 2'd3, 32'h000000FF);
    chk(0, 0, 2'd3, 32'h0, "ecap_clear");
    wr(0, 2'd0, 32'hFFFFFFFF);
    wr(0, 2'd1, 32'hFFFFFFFF);
    chk(0, 0, 2'd0, 32'h000000A5, "data_wr_ignored");
    chk(0, 0, 2'd1, 32'h0, "reserved_read");
    in_a = 8'h00;
    tick(4);
    chk(0, 0, 2'd3, 32'h0, "no_fall_capture");
    chk(0, 0, 2'd0, 32'h0, "data_zero");

    // Rising edge interrupt, clear, no re-set while held high
    wr(0, 2'd2, 32'hFFFFFF01);
    chk(0, 0, 2'd2, 32'h00000001, "mask_a");
    in_a = 8'h01;
    tick(2);
    chk(0, 1, 2'd0, 32'h1, "irq_rise");
    chk(0, 0, 2'd3, 32'h1, "ecap_b0");
    wr(0, 2'd3, 32'h1);
    chk(0, 1, 2'd0, 32'h0, "irq_cleared");
    tick(5);
    chk(0, 0, 2'd3, 32'h0, "no_reset_hold");

    // Clear coincident with a new edge: set wins
    in_a = 8'h00;
    tick(4);
    in_a = 8'h01;
    tick(2);
    wr(0, 2'd3, 32'h1);
    chk(0, 0, 2'd3, 32'h1, "set_wins");
    chk(0, 1, 2'd0, 32'h1, "irq_set_wins");
    wr(0, 2'd2, 32'h0);
    chk(0, 1, 2'd0, 32'h0, "irq_masked");

    // Debouncer: 3-cycle glitch rejected, 4-cycle pulse accepted
    in_b = 8'h04;
    tick(3);
    in_b = 8'h00;
    tick(6);
    chk(1, 0, 2'd0, 32'h0, "glitch_data");
    chk(1, 0, 2'd3, 32'h0, "glitch_ecap");
    in_b = 8'h04;
    tick(4);
    in_b = 8'h00;
    tick(1);
    chk(1, 0, 2'd0, 32'h0, "db_not_yet");
    chk(1, 0, 2'd0, 32'h4, "db_accept");
    chk(1, 0, 2'd3, 32'h4, "db_ecap");
    tick(5);
    chk(1, 0, 2'd0, 32'h0, "db_release");

    // Level interrupt
    wr(2, 2'd2, 32'hFFFF0080);
    chk(2, 0, 2'd2, 32'h00000080, "mask_c");
    in_c = 8'h80;
    chk(2, 1, 2'd0, 32'h0, "lvl_latency");
    chk(2, 1, 2'd0, 32'h1, "lvl_high");
    in_c = 8'h00;
    chk(2, 1, 2'd0, 32'h1, "lvl_hold");
    chk(2, 1, 2'd0, 32'h0, "lvl_low");
    in_c = 8'h01;
    tick(3);
    chk(2, 1, 2'd0, 32'h0, "lvl_unmasked");
    chk(2, 0, 2'd0, 32'h1, "data_c");

    tick(3);
    if (q.size() != 0) begin
      checks++;
      errors += q.size();
      $display("FAIL scoreboard_leftover: actual %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pio_in_irq.md
Name: pio_in_irq

Overview:
- Parametrised Avalon-MM input PIO, successor to the single-bit input port.
- Samples a WIDTH-bit asynchronous input bus through a synchronizer and an optional per-bit debouncer.
- Detects edges into a sticky edge-capture register and raises a maskable interrupt.
- Sits on the system interconnect as a slave; used for USB controller status pins, push-buttons and switches.

Parameters:
- WIDTH, 8, number of input bits; legal range 1..32.
- SYNC_STAGES, 2, synchronizer flop stages per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a bit change is accepted; 0 bypasses the debouncer.
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- IRQ_TYPE, 0, interrupt source: 0 edge (edge-capture register), 1 level (debounced data).

Ports:
- clk  input  1  system clock; sole clock domain.
- reset  input  1  synchronous, active-high reset.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request, active-high.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset clears every register: synchronizer, debouncer stable values and counters, previous-value register, irqmask, edgecapture and readdata. irq is 0 while reset is asserted.
- Synchronizer: in_port passes through SYNC_STAGES flops per bit; sync = last stage.
- Debouncer, DEBOUNCE_CYCLES=0:
  - stable = sync (wire).
  - data path latency in_port -> stable is SYNC_STAGES cycles.
- Debouncer, DEBOUNCE_CYCLES>0, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync==stable, counter <= 0.
  - Otherwise counter increments. When counter reaches DEBOUNCE_CYCLES-1 while still differing, stable <= sync and counter <= 0.
  - A change must persist DEBOUNCE_CYCLES consecutive cycles to be accepted. A glitch shorter than that leaves stable unchanged and restarts the count.
- Edge detect:
  - prev <= stable every cycle.
  - rise = stable & ~prev; fall = ~stable & prev; edge is selected by EDGE_TYPE.
- Register map (word addresses):
  - 0 data, RO: stable, zero-extended.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask, RW: bits [WIDTH-1:0]; upper writedata bits ignored.
  - 3 edgecapture, W1C.
- edgecapture per bit:
  - Sets on a detected edge.
  - Clears when chipselect & ~write_n & address==3 & writedata[i].
  - Simultaneous set and clear on the same bit: set wins.
- Writes to address 0 are ignored.
- readdata: registered every cycle from the address mux, independent of chipselect. Read latency is 1 cycle. Bits [31:WIDTH] are always 0.
- irq: combinational from registers, no extra cycle.
  - IRQ_TYPE=0: irq = |(edgecapture & irqmask).
  - IRQ_TYPE=1: irq = |(stable & irqmask).
- Reset release with in_port high: stable rises after SYNC_STAGES (+DEBOUNCE_CYCLES) cycles. With EDGE_TYPE 0 or 2 this is captured as a rising edge; this is intended behaviour.
- Reset mid-debounce: counts are discarded and the debouncer restarts from stable=0.

Test Plan:
- Reset, then read all four addresses with in_port=0 -> readdata 0 on every address; irq=0.
- WIDTH=8, DEBOUNCE_CYCLES=0: drive in_port=8'hA5 -> address 0 reads 32'h000000A5 once SYNC_STAGES+1 cycles have passed since in_port changed.
- EDGE_TYPE=0, irqmask=8'h01: pulse in_port[0] 0->1 -> edgecapture=1 and irq=1. Write 32'h1 to address 3 -> edgecapture=0, irq=0. Keep in_port[0]=1 -> no re-set.
- Same configuration: issue the address-3 clear of bit0 in the same cycle a new rising edge on bit0 is detected -> bit0 remains 1.
- DEBOUNCE_CYCLES=4: 3-cycle high glitch on bit2 -> data bit2 stays 0. A 4-cycle high on bit2 -> data bit2=1 after SYNC_STAGES+4 cycles.
- IRQ_TYPE=1, irqmask=8'h80: in_port[7] high -> irq=1. in_port[7] low -> irq=0 after synchronizer latency. Write 32'hFFFF0080 to address 2 -> address 2 reads 32'h00000080.
